// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner id and
// the registered memory transaction.
package mem_arb_pkg;

    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_LS
    } owner_e;

    // Captured at accept; drives the mem_* request fields until the response.
    typedef struct packed {
        logic [MEM_AW-1:0]   addr;
        logic                we;
        logic [MEM_DW-1:0]   wdata;
        logic [MEM_DW/8-1:0] be;
    } mem_txn_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory handshakes around the arbiter.
// slave: the arbiter's view. master: the core requesters plus the memory.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_valid;
    logic          if_ready;
    logic [AW-1:0] if_addr;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rdata;
    logic          if_rsp_err;

    logic            ls_valid;
    logic            ls_ready;
    logic [AW-1:0]   ls_addr;
    logic            ls_we;
    logic [DW-1:0]   ls_wdata;
    logic [DW/8-1:0] ls_be;
    logic            ls_rsp_valid;
    logic [DW-1:0]   ls_rdata;
    logic            ls_rsp_err;

    logic            mem_req;
    logic            mem_gnt;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    logic busy;

    modport slave (
        input  if_valid, if_addr,
        output if_ready, if_rsp_valid, if_rdata, if_rsp_err,
        input  ls_valid, ls_addr, ls_we, ls_wdata, ls_be,
        output ls_ready, ls_rsp_valid, ls_rdata, ls_rsp_err,
        output mem_req, mem_addr, mem_we, mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output busy
    );

    modport master (
        output if_valid, if_addr,
        input  if_ready, if_rsp_valid, if_rdata, if_rsp_err,
        output ls_valid, ls_addr, ls_we, ls_wdata, ls_be,
        input  ls_ready, ls_rsp_valid, ls_rdata, ls_rsp_err,
        input  mem_req, mem_addr, mem_we, mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Response watchdog. Cleared when the memory grants, counts while enabled,
// saturates instead of wrapping. expired fires in the cycle whose increment
// would bring the count to TIMEOUT-1, so the registered error response lands
// exactly TIMEOUT cycles after the grant.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 2);
    localparam logic [CW-1:0] TOP  = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // Count cycles spent waiting; hold at TOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != TOP)
            count <= count + CW'(1);
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch (IF)
// and load/store (LS). One transaction in flight; a watchdog turns a lost
// memory response into an error response.
// Build option: define ARB_RR_EN for round-robin arbitration; otherwise LS
// has fixed priority over IF.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = MEM_AW,
    parameter int DW      = MEM_DW,
    parameter int TIMEOUT = 64
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    state_e   state, state_nxt;
    owner_e   owner;
    mem_txn_t txn;

    logic grant_if, grant_ls, accept;
    logic wd_clear, wd_en, wd_expired;
    logic rsp_fire, rsp_err;
    logic [DW-1:0] rsp_data;

    logic          if_rsp_q, if_err_q, ls_rsp_q, ls_err_q;
    logic [DW-1:0] if_rdata_q, ls_rdata_q;

`ifdef ARB_RR_EN
    owner_e rr_last;
`endif

    // Pick a winner among valid requesters; only possible in IDLE.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state == IDLE && !rst) begin
`ifdef ARB_RR_EN
            if (bus.if_valid && bus.ls_valid) begin
                grant_ls = (rr_last == OWN_IF);
                grant_if = (rr_last == OWN_LS);
            end else begin
                grant_if = bus.if_valid;
                grant_ls = bus.ls_valid;
            end
`else
            grant_ls = bus.ls_valid;
            grant_if = bus.if_valid && !bus.ls_valid;
`endif
        end
    end

    assign accept      = grant_if || grant_ls;
    assign bus.if_ready = grant_if;
    assign bus.ls_ready = grant_ls;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and state-decoded controls.
    always_comb begin
        state_nxt   = state;
        bus.mem_req = 1'b0;
        bus.busy    = 1'b1;
        wd_clear    = 1'b0;
        wd_en       = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (accept)
                    state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.mem_req = 1'b1;
                if (bus.mem_gnt) begin
                    wd_clear  = 1'b1;
                    state_nxt = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                wd_en = 1'b1;
                if (bus.mem_rvalid || wd_expired)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    // Capture the winning request; IF is always a full-word read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            txn   <= '0;
            owner <= OWN_IF;
        end else if (accept) begin
            if (grant_ls) begin
                owner     <= OWN_LS;
                txn.addr  <= bus.ls_addr;
                txn.we    <= bus.ls_we;
                txn.wdata <= bus.ls_wdata;
                txn.be    <= bus.ls_be;
            end else begin
                owner     <= OWN_IF;
                txn.addr  <= bus.if_addr;
                txn.we    <= 1'b0;
                txn.wdata <= '0;
                txn.be    <= '1;
            end
        end
    end

`ifdef ARB_RR_EN
    // Remember who was granted last; moves only on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rr_last <= OWN_IF;
        else if (accept)
            rr_last <= grant_ls ? OWN_LS : OWN_IF;
    end
`endif

    assign bus.mem_addr  = txn.addr;
    assign bus.mem_we    = txn.we;
    assign bus.mem_wdata = txn.wdata;
    assign bus.mem_be    = txn.be;

    // rvalid beats the watchdog when both land in the same cycle.
    assign rsp_fire = (state == WAIT_RSP) && (bus.mem_rvalid || wd_expired);
    assign rsp_err  = !bus.mem_rvalid;
    assign rsp_data = (bus.mem_rvalid && !txn.we) ? bus.mem_rdata : '0;

    // One-cycle response pulse to the owner only; idle outputs read as zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rsp_q   <= 1'b0;
            if_err_q   <= 1'b0;
            if_rdata_q <= '0;
            ls_rsp_q   <= 1'b0;
            ls_err_q   <= 1'b0;
            ls_rdata_q <= '0;
        end else begin
            if_rsp_q   <= 1'b0;
            if_err_q   <= 1'b0;
            if_rdata_q <= '0;
            ls_rsp_q   <= 1'b0;
            ls_err_q   <= 1'b0;
            ls_rdata_q <= '0;
            if (rsp_fire) begin
                if (owner == OWN_LS) begin
                    ls_rsp_q   <= 1'b1;
                    ls_err_q   <= rsp_err;
                    ls_rdata_q <= rsp_data;
                end else begin
                    if_rsp_q   <= 1'b1;
                    if_err_q   <= rsp_err;
                    if_rdata_q <= rsp_data;
                end
            end
        end
    end

    assign bus.if_rsp_valid = if_rsp_q;
    assign bus.if_rsp_err   = if_err_q;
    assign bus.if_rdata     = if_rdata_q;
    assign bus.ls_rsp_valid = ls_rsp_q;
    assign bus.ls_rsp_err   = ls_err_q;
    assign bus.ls_rdata     = ls_rdata_q;

endmodule
